// File: rtl/sorted_array_serializer.sv
// sorted_array_serializer
// Latches a packed array of DIM elements on a load strobe and emits it one
// element per valid/ready handshake, flagging the final element with m_last.
// Optional build macro SORTED_SER_DESCEND_EN: when defined, elements are
// emitted from index DIM-1 down to 0 instead of 0 up to DIM-1.
module sorted_array_serializer #(
  parameter int DIM   = 10,
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [IDX_W-1:0]     m_idx,
  output logic                 m_last,
  output logic                 busy
);

  // The index counter must be able to address every element.
  if ((2 ** IDX_W) < DIM) begin : g_idx_w_check
    $error("sorted_array_serializer: IDX_W too small for DIM");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

`ifdef SORTED_SER_DESCEND_EN
  // Descending walk: start at the top element, finish at element 0.
  localparam logic [IDX_W-1:0] FIRST_IDX = LAST_IDX;
  localparam logic [IDX_W-1:0] END_IDX   = '0;
`else
  // Ascending walk: start at element 0, finish at the top element.
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] END_IDX   = LAST_IDX;
`endif

  state_t                 state, state_next;
  logic [IDX_W-1:0]       count, count_next;
  logic [DIM*WIDTH-1:0]   shadow;
  logic [WIDTH-1:0]       elem;
  logic                   at_end;
  logic                   load;

  assign at_end = (count == END_IDX);
  assign load   = (state == IDLE) && in_valid;

  // State and element-counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Shadow copy of the offered array, captured only while idle.
  // NOTE: this wide datapath register is reset on purpose so the held array
  // is a known zero after reset; storage that is always written before it is
  // read would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= in_data;
    end
  end

  // Next-state and counter update: load in IDLE, step or finish on transfer.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = SEND;
          count_next = FIRST_IDX;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (at_end) begin
            state_next = IDLE;
            count_next = '0;
          end else begin
`ifdef SORTED_SER_DESCEND_EN
            count_next = count - IDX_W'(1);
`else
            count_next = count + IDX_W'(1);
`endif
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Element select from the shadow register by the current counter value;
  // compared against each legal index so no out-of-range slice is formed.
  always_comb begin
    elem = '0;
    for (int k = 0; k < DIM; k++) begin
      if (count == IDX_W'(k)) begin
        elem = shadow[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stream outputs depend on registered state only, never on m_ready.
  assign m_valid  = (state == SEND);
  assign m_data   = m_valid ? elem  : '0;
  assign m_idx    = m_valid ? count : '0;
  assign m_last   = m_valid && at_end;
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

endmodule

// File: doc/sorted_array_serializer.md
Name: sorted_array_serializer

Overview:
- Reads the packed sorted vector produced by the single-cycle bubble sorter and emits its elements one per handshake on a valid/ready stream.
- Sits downstream of the sorter.
- Latches a whole packed array on a load strobe, then walks through it with an index counter.
- Marks the final element with a last flag.

Parameters:
DIM, 10, number of elements in the packed array
WIDTH, 8, bits per element
IDX_W, 4, width of element index output; must satisfy 2**IDX_W >= DIM

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  packed array on in_data is offered this cycle
in_ready  output  1  block can accept a new array (high only in IDLE)
in_data  input  DIM*WIDTH  packed sorted array; element k at bits [k*WIDTH +: WIDTH]
m_valid  output  1  m_data holds a valid element
m_ready  input  1  downstream accepts element this cycle
m_data  output  WIDTH  current element
m_idx  output  IDX_W  index of current element within the array
m_last  output  1  current element is the final one of the array
busy  output  1  array held, not yet fully emitted (inverse of in_ready)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; shadow register cleared to 0; counter 0; m_valid 0, m_data 0, m_idx 0, m_last 0, busy 0, in_ready 1. Reset mid-stream discards the held array; no partial resume.
- States: IDLE, SEND.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, latch in_data into the shadow register, set counter 0, go to SEND.
  - Latency load to first m_valid: 1 cycle.
- SEND:
  - in_ready = 0; in_valid is ignored and the array is not latched.
  - m_valid = 1.
  - m_data = shadow element[counter].
  - m_idx = counter.
  - m_last = (counter == DIM-1).
- Handshake: a transfer occurs on an edge with m_valid=1 and m_ready=1.
  - Transfer with counter < DIM-1: counter increments; next element is presented the following cycle.
  - Transfer with m_last=1: go to IDLE; counter returns to 0; m_valid drops the next cycle.
  - No back-to-back load in the same cycle as the last transfer: new arrays are accepted only from the following IDLE cycle. Minimum period per array is DIM+1 cycles.
- Stall: while m_ready=0, m_data, m_idx and m_last hold stable and m_valid stays high. m_valid never deasserts without a transfer.
- m_data, m_idx and m_last are driven from registers and the shadow mux only. No combinational path from m_ready to m_valid or m_data.
- Counter never exceeds DIM-1; no wrap-around is possible in SEND.
- DIM=1: the single element is presented with m_last=1 immediately.
- Outputs in IDLE: m_data, m_idx and m_last are 0. The shadow register keeps its last value internally.
- Element order is ascending index (0..DIM-1). With the sorter's output this yields ascending values.

Optional Feature:
Macro SORTED_SER_DESCEND_EN.
- Defined:
  - Elements are emitted from index DIM-1 down to 0.
  - Counter loads DIM-1 on accept and decrements per transfer.
  - m_idx reports the true element index (DIM-1 first).
  - m_last asserts when the counter reaches 0.
  - Timing and handshake are identical to the undefined case.
- Undefined: ascending order as described above.

Test Plan:
1. Reset while streaming (DIM=4, WIDTH=8), rst_n low mid-SEND -> outputs 0 asynchronously, in_ready=1, busy=0; after release m_valid stays 0 until a new load.
2. Load in_data=0x40302010 with m_ready held 1 -> starting 1 cycle after load, m_data = 0x10, 0x20, 0x30, 0x40 on consecutive cycles; m_idx = 0..3; m_last only on 0x40; in_ready returns 1 the cycle after.
3. Same load with m_ready toggling 1,0,0,1,1,0,1 -> each element held stable during stalls; exactly 4 transfers; no element skipped or repeated.
4. in_valid held high throughout SEND with a second array 0xDDCCBBAA -> the first array is emitted intact; the second is latched only in the IDLE cycle after the last transfer, and its first element 0xAA appears 1 cycle later.
5. DIM=1, in_data=0x7F -> a single beat, m_data=0x7F, m_idx=0, m_last=1.
6. With SORTED_SER_DESCEND_EN and in_data=0x40302010 -> m_data 0x40, 0x30, 0x20, 0x10; m_idx 3, 2, 1, 0; m_last on 0x10.
